// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: rotate-left/right, bounce or hold, advanced once per `period` enabled cycles.
// Pattern and step update on the tick edge; optional PWM output gating under LED_SEQ_PWM_EN.
module led_pattern_sequencer #(
    parameter int                      COUNT_WIDTH   = 32,
    parameter int                      OUTPUT_WIDTH  = 4,
    parameter logic [OUTPUT_WIDTH-1:0] RESET_PATTERN = 4'b0011,
    parameter int                      PWM_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [COUNT_WIDTH-1:0]  period,
    input  logic                    load,
    input  logic [OUTPUT_WIDTH-1:0] load_pattern,
    input  logic [PWM_WIDTH-1:0]    duty,
    output logic [OUTPUT_WIDTH-1:0] pattern,
    output logic [OUTPUT_WIDTH-1:0] out,
    output logic                    step,
    output logic                    dir
);

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]  limit;
    logic [OUTPUT_WIDTH-1:0] pattern_q, pattern_d;
    logic [OUTPUT_WIDTH-1:0] rot_l, rot_r;
    dir_t                    dir_q, dir_d;
    logic                    step_q, step_d;
    logic                    tick;

    // period 0 behaves like 1; >= lets a lowered period fire on the next enabled cycle
    assign limit = (period == '0) ? '0 : period - 1'b1;
    assign tick  = enable && (cnt_q >= limit);
    assign rot_l = {pattern_q[OUTPUT_WIDTH-2:0], pattern_q[OUTPUT_WIDTH-1]};
    assign rot_r = {pattern_q[0], pattern_q[OUTPUT_WIDTH-1:1]};

    always_comb begin
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        if (load) begin
            pattern_d = load_pattern;
            cnt_d     = '0;
            dir_d     = DIR_LEFT;
        end else if (enable) begin
            if (tick) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (mode)
                    MODE_ROT_L:  pattern_d = rot_l;
                    MODE_ROT_R:  pattern_d = rot_r;
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            if (pattern_q[OUTPUT_WIDTH-1]) begin
                                dir_d     = DIR_RIGHT;
                                pattern_d = rot_r;
                            end else begin
                                pattern_d = rot_l;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                dir_d     = DIR_LEFT;
                                pattern_d = rot_l;
                            end else begin
                                pattern_d = rot_r;
                            end
                        end
                    end
                    default: pattern_d = pattern_q;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pattern_q <= RESET_PATTERN;
            dir_q     <= DIR_LEFT;
            step_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
        end
    end

    assign pattern = pattern_q;
    assign step    = step_q;
    assign dir     = dir_q;

`ifdef LED_SEQ_PWM_EN
    logic [PWM_WIDTH-1:0]    pwm_cnt;
    logic [OUTPUT_WIDTH-1:0] out_q;

    // out lags pattern by one cycle because the gate is registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            out_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            out_q   <= pattern_q & {OUTPUT_WIDTH{(pwm_cnt < duty)}};
        end
    end

    assign out = out_q;
`else
    logic unused_duty;

    assign unused_duty = ^duty;
    assign out         = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer (default build, W=4, RESET_PATTERN=0011).
module tb_led_pattern_sequencer;

    localparam logic [1:0] ROT_L  = 2'b00;
    localparam logic [1:0] ROT_R  = 2'b01;
    localparam logic [1:0] BOUNCE = 2'b10;
    localparam logic [1:0] HOLD   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = ROT_L;
    logic [31:0] period = 32'd3;
    logic        load = 1'b0;
    logic [3:0]  load_pattern = 4'b0000;
    logic [7:0]  duty = 8'd0;
    logic [3:0]  pattern;
    logic [3:0]  out;
    logic        step;
    logic        dir;

    int errors = 0;
    int checks = 0;

    led_pattern_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .period       (period),
        .load         (load),
        .load_pattern (load_pattern),
        .duty         (duty),
        .pattern      (pattern),
        .out          (out),
        .step         (step),
        .dir          (dir)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        load  = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        enable = 1'b1; mode = ROT_L; period = 32'd3;
        do_reset();
        checks++; if (pattern !== 4'b0011) begin errors++; $display("FAIL reset_pattern: got %b want 0011", pattern); end
        checks++; if (out !== 4'b0011) begin errors++; $display("FAIL reset_out: got %b want 0011", out); end
        checks++; if (step !== 1'b0 || dir !== 1'b0) begin errors++; $display("FAIL reset_step_dir: got step=%b dir=%b want 0 0", step, dir); end
    endtask

    task automatic test_rot_l;
        logic [3:0] exp_p [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};
        logic [3:0] prev;
        enable = 1'b1; mode = ROT_L; period = 32'd3;
        do_reset();
        prev = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 2; c++) begin
                cyc();
                checks++; if (step !== 1'b0 || pattern !== prev) begin errors++; $display("FAIL rotl_idle[%0d.%0d]: got step=%b pat=%b want 0 %b", i, c, step, pattern, prev); end
            end
            cyc();
            checks++; if (step !== 1'b1 || pattern !== exp_p[i]) begin errors++; $display("FAIL rotl_step[%0d]: got step=%b pat=%b want 1 %b", i, step, pattern, exp_p[i]); end
            checks++; if (out !== exp_p[i]) begin errors++; $display("FAIL rotl_out[%0d]: got %b want %b", i, out, exp_p[i]); end
            prev = exp_p[i];
        end
    endtask

    task automatic test_rot_r;
        logic [3:0] exp_p [4] = '{4'b1001, 4'b1100, 4'b0110, 4'b0011};
        enable = 1'b1; mode = ROT_R; period = 32'd1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (step !== 1'b1 || pattern !== exp_p[i]) begin errors++; $display("FAIL rotr[%0d]: got step=%b pat=%b want 1 %b", i, step, pattern, exp_p[i]); end
        end
        // period 0 must behave like period 1
        period = 32'd0; mode = ROT_L;
        do_reset();
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b0110) begin errors++; $display("FAIL period0_a: got step=%b pat=%b want 1 0110", step, pattern); end
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b1100) begin errors++; $display("FAIL period0_b: got step=%b pat=%b want 1 1100", step, pattern); end
    endtask

    task automatic test_bounce;
        logic [3:0] exp_p [5] = '{4'b0110, 4'b1100, 4'b0110, 4'b0011, 4'b0110};
        logic       exp_d [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        enable = 1'b1; mode = BOUNCE; period = 32'd2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (step !== 1'b0) begin errors++; $display("FAIL bounce_idle[%0d]: got step=%b want 0", i, step); end
            cyc();
            checks++; if (step !== 1'b1 || pattern !== exp_p[i] || dir !== exp_d[i]) begin
                errors++; $display("FAIL bounce[%0d]: got step=%b pat=%b dir=%b want 1 %b %b", i, step, pattern, dir, exp_p[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_enable;
        enable = 1'b1; mode = ROT_L; period = 32'd3;
        do_reset();
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (step !== 1'b0 || pattern !== 4'b0011) begin errors++; $display("FAIL freeze[%0d]: got step=%b pat=%b want 0 0011", i, step, pattern); end
        end
        enable = 1'b1;
        cyc();
        checks++; if (step !== 1'b0 || pattern !== 4'b0011) begin errors++; $display("FAIL resume_a: got step=%b pat=%b want 0 0011", step, pattern); end
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b0110) begin errors++; $display("FAIL resume_b: got step=%b pat=%b want 1 0110", step, pattern); end
        cyc();
        enable = 1'b0; load = 1'b1; load_pattern = 4'b1000;
        cyc();
        load = 1'b0;
        checks++; if (pattern !== 4'b1000 || dir !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL load_disabled: got pat=%b dir=%b step=%b want 1000 0 0", pattern, dir, step); end
        enable = 1'b1;
        cyc(); cyc();
        checks++; if (step !== 1'b0 || pattern !== 4'b1000) begin errors++; $display("FAIL load_cnt_zero: got step=%b pat=%b want 0 1000", step, pattern); end
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b0001) begin errors++; $display("FAIL load_first_tick: got step=%b pat=%b want 1 0001", step, pattern); end
    endtask

    task automatic test_load;
        enable = 1'b1; mode = BOUNCE; period = 32'd1;
        do_reset();
        cyc(); cyc(); cyc();
        checks++; if (pattern !== 4'b0110 || dir !== 1'b1) begin errors++; $display("FAIL load_pre: got pat=%b dir=%b want 0110 1", pattern, dir); end
        load = 1'b1; load_pattern = 4'b1000;
        cyc();
        load = 1'b0;
        checks++; if (pattern !== 4'b1000 || dir !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL load_over_tick: got pat=%b dir=%b step=%b want 1000 0 0", pattern, dir, step); end
        cyc();
        checks++; if (pattern !== 4'b0100 || dir !== 1'b1 || step !== 1'b1) begin errors++; $display("FAIL load_bounce: got pat=%b dir=%b step=%b want 0100 1 1", pattern, dir, step); end
    endtask

    task automatic test_period_drop;
        enable = 1'b1; mode = ROT_L; period = 32'd100;
        do_reset();
        repeat (50) cyc();
        checks++; if (step !== 1'b0 || pattern !== 4'b0011) begin errors++; $display("FAIL drop_pre: got step=%b pat=%b want 0 0011", step, pattern); end
        period = 32'd2;
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b0110) begin errors++; $display("FAIL drop_tick: got step=%b pat=%b want 1 0110", step, pattern); end
        cyc();
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL drop_gap: got step=%b want 0", step); end
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b1100) begin errors++; $display("FAIL drop_next: got step=%b pat=%b want 1 1100", step, pattern); end
    endtask

    task automatic test_reset_mid;
        enable = 1'b1; mode = ROT_L; period = 32'd3;
        do_reset();
        repeat (4) cyc();
        checks++; if (pattern !== 4'b0110) begin errors++; $display("FAIL rstmid_pre: got %b want 0110", pattern); end
        do_reset();
        checks++; if (pattern !== 4'b0011 || step !== 1'b0) begin errors++; $display("FAIL rstmid: got pat=%b step=%b want 0011 0", pattern, step); end
        cyc(); cyc();
        checks++; if (step !== 1'b0 || pattern !== 4'b0011) begin errors++; $display("FAIL rstmid_restart: got step=%b pat=%b want 0 0011", step, pattern); end
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b0110) begin errors++; $display("FAIL rstmid_tick: got step=%b pat=%b want 1 0110", step, pattern); end
    endtask

    task automatic test_hold_degenerate;
        enable = 1'b1; mode = ROT_L; period = 32'd3;
        do_reset();
        cyc();
        mode = HOLD;
        cyc();
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL hold_gap: got step=%b want 0", step); end
        cyc();
        checks++; if (step !== 1'b1 || pattern !== 4'b0011) begin errors++; $display("FAIL hold_tick: got step=%b pat=%b want 1 0011", step, pattern); end
        load = 1'b1; load_pattern = 4'b0000; mode = ROT_L; period = 32'd1;
        cyc();
        load = 1'b0;
        for (int m = 0; m < 3; m++) begin
            mode = 2'(m);
            cyc();
            checks++; if (pattern !== 4'b0000 || step !== 1'b1) begin errors++; $display("FAIL zeros[%0d]: got pat=%b step=%b want 0000 1", m, pattern, step); end
        end
        load = 1'b1; load_pattern = 4'b1111; mode = BOUNCE;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (pattern !== 4'b1111 || dir !== ((i % 2) == 0)) begin errors++; $display("FAIL ones_bounce[%0d]: got pat=%b dir=%b want 1111 %0d", i, pattern, dir, (i % 2) == 0); end
        end
        mode = ROT_L;
        cyc();
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL dir_kept: got %b want 1", dir); end
    endtask

    initial begin
        test_reset();
        test_rot_l();
        test_rot_r();
        test_bounce();
        test_enable();
        test_load();
        test_period_drop();
        test_reset_mid();
        test_hold_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Parametrised successor to the fixed-rotate LED looper.
- Holds an OUTPUT_WIDTH-bit LED pattern and advances it once every `period` enabled clock cycles.
- Run-time selectable modes: rotate-left, rotate-right, bounce (ping-pong) and hold.
- Adds run-time period, enable, seed load and a step strobe; drives board LEDs directly, or feeds a downstream status block.

Parameters:
- COUNT_WIDTH, 32, width of the prescale counter and the `period` input.
- OUTPUT_WIDTH, 4, number of pattern bits / LEDs. Must be at least 2.
- RESET_PATTERN, 4'b0011 (OUTPUT_WIDTH bits), pattern loaded at reset.
- PWM_WIDTH, 8, width of the brightness duty input. Used only with LED_SEQ_PWM_EN.

Ports:
- clk  input  1  system clock (100 MHz on board).
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  1 = counter runs and pattern advances; 0 = freeze counter and pattern.
- mode  input  2  00 ROT_L, 01 ROT_R, 10 BOUNCE, 11 HOLD.
- period  input  COUNT_WIDTH  cycles per step; values 0 and 1 both mean a step every enabled cycle.
- load  input  1  one-cycle request to load load_pattern.
- load_pattern  input  OUTPUT_WIDTH  seed value for load.
- duty  input  PWM_WIDTH  LED brightness; ignored unless LED_SEQ_PWM_EN is defined.
- pattern  output  OUTPUT_WIDTH  registered current pattern.
- out  output  OUTPUT_WIDTH  LED drive: pattern, or pattern gated by PWM.
- step  output  1  one-cycle pulse, registered, high in the same cycle the updated pattern first appears.
- dir  output  1  bounce direction: 0 = left (toward MSB), 1 = right.

Behaviour:
- All state updates on posedge clk. Priority order: rst_n low, then load, then enable/tick.
- Reset (rst_n=0 at an edge):
  - pattern=RESET_PATTERN, counter=0, dir=0, step=0, PWM counter=0.
  - out=RESET_PATTERN without PWM; out=0 with PWM.
  - Reset mid-step discards the partial count.
- Load (load=1, rst_n=1):
  - pattern<=load_pattern, counter<=0, dir<=0, step<=0.
  - Load takes effect even when enable=0. A tick in the same cycle is discarded.
- Prescaler, with enable=1 and load=0:
  - tick = (counter >= period-1), computed using max(period,1).
  - On tick: counter<=0. Otherwise counter<=counter+1.
  - The >= comparison means that if period is lowered below the current count, a tick occurs on the next enabled cycle; the counter never wraps past 2^COUNT_WIDTH.
- enable=0: counter, pattern, dir hold; step=0.
- On tick, step<=1 the following edge-cycle (every mode, including HOLD). Otherwise step<=0.
- Pattern update on tick (rotations are lossless, no bits dropped):
  - ROT_L: pattern <= {pattern[W-2:0], pattern[W-1]}.
  - ROT_R: pattern <= {pattern[0], pattern[W-1:1]}.
  - BOUNCE, dir=0:
    - If pattern[W-1]=1: dir<=1 and pattern rotates right.
    - Else: rotate left.
  - BOUNCE, dir=1:
    - If pattern[0]=1: dir<=0 and pattern rotates left.
    - Else: rotate right.
  - HOLD: pattern and dir unchanged.
- dir changes only in BOUNCE or on load/reset. Leaving BOUNCE keeps dir.
- Mode and period are sampled live. A mode change applies at the next tick and does not reset the counter.
- Degenerate patterns:
  - All-zeros stays all-zeros in every mode.
  - All-ones in BOUNCE toggles dir every tick with an unchanged pattern. This is legal and defined.
- Latency: the pattern changes on the edge at which tick is true; step is asserted in the same cycle as the new pattern.

Optional Feature:
- Macro LED_SEQ_PWM_EN.
- Defined:
  - A free-running PWM_WIDTH-bit counter increments every clk (wraps), independent of enable.
  - out = pattern & {W{pwm_cnt < duty}}, registered (one cycle behind pattern).
  - duty=0 gives LEDs always off; duty=2^PWM_WIDTH-1 gives on 255/256 of cycles.
- Not defined:
  - out = pattern (combinational copy), duty unused, no PWM counter logic.

Test Plan (W=4, RESET_PATTERN=0011):
- Reset, enable=1, mode=ROT_L, period=3 -> pattern 0011 after reset; 0110 after 3 cycles, then 1100, 1001, 0011; step high exactly 1 cycle per change, every 3rd cycle.
- mode=ROT_R, period=1 -> pattern 0011, 1001, 1100, 0110 on consecutive cycles; step continuously high.
- mode=BOUNCE, period=2 from reset -> 0110, 1100, 0110 (dir=1), 0011, 0110 (dir=0); dir toggles when the MSB or LSB is set.
- enable=0 for 10 cycles mid-count, then re-enable -> pattern frozen, step=0; the remaining count resumes without restart. Assert load=1, load_pattern=1000 with enable=0 -> pattern=1000, dir=0, counter=0 next cycle.
- Drop period from 100 to 2 while counter=50 -> tick on next enabled cycle, then every 2 cycles. rst_n=0 at counter=1 of period 3 -> pattern=0011, counter restarts at 0.
- With LED_SEQ_PWM_EN, duty=64, PWM_WIDTH=8, mode=HOLD -> out equals pattern for 64 of every 256 cycles, else 0000. duty=0 -> out always 0000.
